// File: rtl/tm1637_rx_pkg.sv
// TM1637 responder shared definitions:
// opcodes, data-command field masks and FSM states.
package tm1637_rx_pkg;

  localparam logic [1:0] OP_DATA = 2'b01;
  localparam logic [1:0] OP_DISP = 2'b10;
  localparam logic [1:0] OP_ADDR = 2'b11;

  localparam logic [7:0] DCMD_KEY_M = 8'h03;
  localparam logic [7:0] DCMD_FIX_M = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ACK,
    S_DATA,
    S_WAIT
  } rx_state_e;

endpackage

// File: rtl/tm1637_line_sync.sv
// Bus line conditioner: synchronizer, optional glitch filter
// (TM1637_RX_FILTER_EN), level plus rise/fall pulses.
// Ports: clk, rst (async, active-low), din -> level, rise, fall.
module tm1637_line_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_cfg
    $error("tm1637_line_sync: bad SYNC_STAGES/FILT_LEN");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt;
  logic                   prev_q;

  // Idle bus is high, so reset the chain to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

`ifdef TM1637_RX_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // cnt_q counts consecutive samples that disagree with filt_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == CW'(FILT_LEN - 1)) begin
      filt_q <= sync_q[SYNC_STAGES-1];
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b1;
    else      prev_q <= filt;
  end

  assign level = filt;
  assign rise  = filt & ~prev_q;
  assign fall  = ~filt & prev_q;

endmodule

// File: rtl/tm1637_rx.sv
// TM1637 device-side receiver: START/STOP, LSB-first bytes,
// ACK drive, command decode, display register write pulses.
// Ports: clk, rst (async, active-low), scl_in, sda_in ->
//   sda_en/sda_out (ACK), wr_valid/wr_addr/wr_data,
//   auto_inc, disp_on, brightness, cmd_err, busy.
// Macro TM1637_RX_FILTER_EN adds a glitch filter per line.
module tm1637_rx
  import tm1637_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DIGITS  = 6,
  parameter int FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_en,
  output logic       sda_out,
  output logic       wr_valid,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       auto_inc,
  output logic       disp_on,
  output logic [2:0] brightness,
  output logic       cmd_err,
  output logic       busy
);

  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  tm1637_line_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_scl (
    .clk  (clk),
    .rst  (rst),
    .din  (scl_in),
    .level(scl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  tm1637_line_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_sda (
    .clk  (clk),
    .rst  (rst),
    .din  (sda_in),
    .level(sda),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  rx_state_e  state_q, state_d;
  rx_state_e  ret_q, ret_d;
  logic [7:0] shreg_q, cur_byte;
  logic [2:0] bit_q, addr_q;
  logic       ack_drv_q, ack_rose_q;
  logic       start_det, stop_det;
  logic       shifting, byte_done, addr_ok;
  logic [1:0] op;

  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;
  assign shifting  = state_q inside {S_CMD, S_DATA, S_WAIT};
  assign byte_done = shifting & scl_rise & (bit_q == 3'd7);
  assign cur_byte  = {sda, shreg_q[7:1]};
  assign op        = cur_byte[7:6];
  assign addr_ok   = 32'(cur_byte[2:0]) < NUM_DIGITS;
  assign sda_out   = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // ret_q remembers where to resume once the ACK clock ends.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    if (start_det) begin
      state_d = S_CMD;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_CMD: if (byte_done) begin
          state_d = S_ACK;
          ret_d   = (op == OP_ADDR && addr_ok) ? S_DATA : S_WAIT;
        end
        S_DATA, S_WAIT: if (byte_done) begin
          state_d = S_ACK;
          ret_d   = state_q;
        end
        S_ACK: if (scl_fall & ack_drv_q & ack_rose_q)
          state_d = ret_q;
        default: ;
      endcase
    end
    sda_en = (state_q == S_ACK) & ack_drv_q
           & ~stop_det & ~start_det;
    busy   = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q    <= '0;
      bit_q      <= '0;
      addr_q     <= '0;
      ack_drv_q  <= 1'b0;
      ack_rose_q <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      auto_inc   <= 1'b1;
      disp_on    <= 1'b0;
      brightness <= '0;
      cmd_err    <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      cmd_err  <= 1'b0;
      if (start_det | stop_det) begin
        bit_q      <= '0;
        ack_drv_q  <= 1'b0;
        ack_rose_q <= 1'b0;
      end else begin
        if (shifting & scl_rise) begin
          shreg_q <= cur_byte;
          bit_q   <= bit_q + 3'd1;
        end
        if (byte_done && state_q == S_CMD) begin
          unique case (1'b1)
            (op == OP_DATA): begin
              if ((cur_byte & DCMD_KEY_M) == 8'h00)
                auto_inc <= (cur_byte & DCMD_FIX_M) == 8'h00;
              else
                cmd_err <= 1'b1;
            end
            (op == OP_ADDR): begin
              addr_q  <= cur_byte[2:0];
              cmd_err <= ~addr_ok;
            end
            (op == OP_DISP): begin
              disp_on    <= cur_byte[3];
              brightness <= cur_byte[2:0];
            end
            default: cmd_err <= 1'b1;
          endcase
        end
        if (byte_done && state_q == S_DATA) begin
          wr_valid <= 1'b1;
          wr_addr  <= addr_q;
          wr_data  <= cur_byte;
          if (auto_inc)
            addr_q <= (addr_q == LAST) ? 3'd0
                                       : addr_q + 3'd1;
        end
        // Drive from the fall after bit 8 to the fall
        // after the 9th rise.
        if (state_q == S_ACK) begin
          if (scl_fall & ~ack_drv_q)
            ack_drv_q <= 1'b1;
          if (scl_rise & ack_drv_q)
            ack_rose_q <= 1'b1;
          if (scl_fall & ack_drv_q & ack_rose_q) begin
            ack_drv_q  <= 1'b0;
            ack_rose_q <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tm1637_rx.sv
// Bench for tm1637_rx: bus master tasks, byte-level model,
// per-cycle write/err monitor plus literal expectations.
module tb_tm1637_rx;

  localparam int H = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in, sda_en, sda_out;
  logic       wr_valid, auto_inc, disp_on, cmd_err, busy;
  logic [2:0] wr_addr, brightness;
  logic [7:0] wr_data;

  int checks = 0;
  int failures = 0;
  int exp_err = 0;
  int err_seen = 0;
  int e0;
  logic [10:0] exp_q[$];
  logic [10:0] wlog[$];
  logic [10:0] exp_w;
  bit          m_auto = 1'b1;
  bit          m_on = 1'b0;
  logic [2:0]  m_bri = 3'd0;
  logic [7:0]  tb_bytes[8];

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~(sda_en & ~sda_out);

  always #5 clk = ~clk;

  tm1637_rx dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_en    (sda_en),
    .sda_out   (sda_out),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .auto_inc  (auto_inc),
    .disp_on   (disp_on),
    .brightness(brightness),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Byte-level model of one transaction's effect.
  task automatic model(input int n);
    logic [7:0] b0;
    int a;
    b0 = tb_bytes[0];
    case (b0[7:6])
      2'b01: begin
        if (b0[1:0] == 2'b00) m_auto = !b0[2];
        else exp_err++;
      end
      2'b10: begin
        m_on  = b0[3];
        m_bri = b0[2:0];
      end
      2'b11: begin
        a = int'(b0[2:0]);
        if (a >= 6) exp_err++;
        else begin
          for (int k = 1; k < n; k++) begin
            exp_q.push_back({3'(a), tb_bytes[k]});
            if (m_auto) a = (a + 1) % 6;
          end
        end
      end
      default: exp_err++;
    endcase
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("wr_err_excl", 32'(wr_valid & cmd_err), 0);
      chk("sda_out", 32'(sda_out), 0);
      if (wr_valid) begin
        wlog.push_back({wr_addr, wr_data});
        chk("wr_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          chk("wr", 32'({wr_addr, wr_data}), 32'(exp_w));
        end
      end
      if (cmd_err) err_seen++;
    end
  end

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start;
    sda_m = 1'b1; w(H);
    scl_m = 1'b1; w(H);
    sda_m = 1'b0; w(H);
    scl_m = 1'b0; w(H);
  endtask

  task automatic m_stop;
    sda_m = 1'b0; w(H);
    scl_m = 1'b1; w(H);
    sda_m = 1'b1; w(H);
  endtask

  task automatic m_bits(input logic [7:0] b, input int nb);
    for (int i = 0; i < nb; i++) begin
      sda_m = b[i]; w(H);
      scl_m = 1'b1; w(H / 2);
      chk("no_drive_bit", 32'(sda_en), 0);
      w(H - H / 2);
      scl_m = 1'b0; w(3);
    end
  endtask

  task automatic m_byte(input logic [7:0] b);
    m_bits(b, 8);
    sda_m = 1'b1; w(H);
    scl_m = 1'b1; w(H / 2);
    chk("ack_sda_en", 32'(sda_en), 1);
    chk("ack_bus", 32'(sda_in), 0);
    chk("busy_in_txn", 32'(busy), 1);
    w(H - H / 2);
    scl_m = 1'b0; w(3);
  endtask

  task automatic end_checks;
    chk("busy_after_stop", 32'(busy), 0);
    chk("sda_en_idle", 32'(sda_en), 0);
    chk("writes_left", exp_q.size(), 0);
    chk("err_count", err_seen, exp_err);
    chk("auto_inc", 32'(auto_inc), 32'(m_auto));
    chk("disp_on", 32'(disp_on), 32'(m_on));
    chk("brightness", 32'(brightness), 32'(m_bri));
  endtask

  task automatic run_txn(input int n);
    model(n);
    wlog.delete();
    m_start;
    for (int k = 0; k < n; k++) m_byte(tb_bytes[k]);
    m_stop;
    w(H);
    end_checks;
  endtask

  initial begin
    w(5);
    chk("rst_sda_en", 32'(sda_en), 0);
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_auto_inc", 32'(auto_inc), 1);
    chk("rst_disp_on", 32'(disp_on), 0);
    chk("rst_bright", 32'(brightness), 0);
    chk("rst_cmd_err", 32'(cmd_err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    w(H);

    tb_bytes[0] = 8'h40;
    run_txn(1);
    chk("t40_auto", 32'(auto_inc), 1);
    chk("t40_nwr", wlog.size(), 0);

    tb_bytes[0] = 8'hC0; tb_bytes[1] = 8'h06;
    tb_bytes[2] = 8'h5B; tb_bytes[3] = 8'h4F;
    tb_bytes[4] = 8'h66;
    run_txn(5);
    chk("seq_n", wlog.size(), 4);
    chk("seq_w0", 32'(wlog[0]), 32'h006);
    chk("seq_w1", 32'(wlog[1]), 32'h15B);
    chk("seq_w2", 32'(wlog[2]), 32'h24F);
    chk("seq_w3", 32'(wlog[3]), 32'h366);

    tb_bytes[0] = 8'h44;
    run_txn(1);
    chk("fix_auto", 32'(auto_inc), 0);
    tb_bytes[0] = 8'hC5; tb_bytes[1] = 8'h11;
    tb_bytes[2] = 8'h22;
    run_txn(3);
    chk("fix_w0", 32'(wlog[0]), 32'h511);
    chk("fix_w1", 32'(wlog[1]), 32'h522);

    tb_bytes[0] = 8'h40;
    run_txn(1);
    tb_bytes[0] = 8'hC5; tb_bytes[1] = 8'h11;
    tb_bytes[2] = 8'h22;
    run_txn(3);
    chk("wrap_w0", 32'(wlog[0]), 32'h511);
    chk("wrap_w1", 32'(wlog[1]), 32'h022);

    tb_bytes[0] = 8'h8F;
    run_txn(1);
    chk("disp_on_lit", 32'(disp_on), 1);
    chk("bright_lit", 32'(brightness), 7);

    e0 = err_seen;
    tb_bytes[0] = 8'hC7; tb_bytes[1] = 8'h12;
    run_txn(2);
    chk("c7_err", err_seen - e0, 1);
    chk("c7_nwr", wlog.size(), 0);

    e0 = err_seen;
    tb_bytes[0] = 8'h42;
    run_txn(1);
    chk("key_err", err_seen - e0, 1);

    e0 = err_seen;
    tb_bytes[0] = 8'h3F;
    run_txn(1);
    chk("op00_err", err_seen - e0, 1);

    // STOP after 4 bits of a data byte.
    tb_bytes[0] = 8'hC0;
    model(1);
    wlog.delete();
    m_start;
    m_byte(8'hC0);
    m_bits(8'hAA, 4);
    m_stop;
    w(H);
    end_checks;
    chk("part_nwr", wlog.size(), 0);

    // Repeated START mid-byte.
    wlog.delete();
    m_start;
    m_byte(8'hC0);
    m_bits(8'hAA, 4);
    m_start;
    chk("rs_busy", 32'(busy), 1);
    tb_bytes[0] = 8'hC1; tb_bytes[1] = 8'h77;
    model(2);
    m_byte(8'hC1);
    m_byte(8'h77);
    m_stop;
    w(H);
    end_checks;
    chk("rs_n", wlog.size(), 1);
    chk("rs_w0", 32'(wlog[0]), 32'h177);

    // Reset mid-byte.
    wlog.delete();
    m_start;
    m_byte(8'hC0);
    m_bits(8'h55, 4);
    rst = 1'b0;
    w(3);
    chk("mrst_sda_en", 32'(sda_en), 0);
    chk("mrst_wr_valid", 32'(wr_valid), 0);
    chk("mrst_wr_addr", 32'(wr_addr), 0);
    chk("mrst_wr_data", 32'(wr_data), 0);
    chk("mrst_auto", 32'(auto_inc), 1);
    chk("mrst_disp_on", 32'(disp_on), 0);
    chk("mrst_bright", 32'(brightness), 0);
    chk("mrst_busy", 32'(busy), 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    w(4);
    rst = 1'b1;
    m_auto = 1'b1;
    m_on = 1'b0;
    m_bri = 3'd0;
    w(H);
    chk("mrst_nwr", wlog.size(), 0);
    tb_bytes[0] = 8'h8B;
    run_txn(1);
    chk("after_rst_on", 32'(disp_on), 1);
    chk("after_rst_bri", 32'(brightness), 3);

`ifdef TM1637_RX_FILTER_EN
    sda_m = 1'b0;
    w(1);
    sda_m = 1'b1;
    w(H);
    chk("glitch_busy", 32'(busy), 0);
    sda_m = 1'b0;
    w(H);
    scl_m = 1'b0;
    w(H);
    scl_m = 1'b1;
    w(H);
    chk("glitch_ref_start", 32'(busy), 1);
    sda_m = 1'b1;
    w(1);
    sda_m = 1'b0;
    w(H);
    chk("glitch_no_stop", 32'(busy), 1);
    sda_m = 1'b1;
    w(H);
    chk("real_stop", 32'(busy), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
